// File: rtl/tdp_ram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tdp_ram_pkg
// Description : Shared types and constants for the parametrised true
//               dual-port RAM (FSM state encoding, read-during-write modes).
// Revision    : 1.0 - initial release
// ============================================================================
package tdp_ram_pkg;

  // Clear-sequencer state encoding
  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } tdp_state_e;

  // Same-port read-during-write behaviour
  localparam int RDW_WRITE_FIRST = 0;  // q shows the data being written
  localparam int RDW_READ_FIRST  = 1;  // q shows the previous contents

endpackage : tdp_ram_pkg
`default_nettype wire

// File: rtl/tdp_ram_port_out.sv
`default_nettype none
// ============================================================================
// Module      : tdp_ram_port_out
// Description : Per-port read-data / valid register. Selects between the
//               write data and the stored word according to the
//               read-during-write mode, and optionally adds a second output
//               register stage.
// Revision    : 1.0 - initial release
//
// Ports:
//   clk      in   clock
//   rst_n    in   asynchronous active-low reset
//   i_access in   port performs an access this cycle (READY and enabled)
//   i_we     in   access is a write
//   i_wdata  in   write data of this port
//   i_rdata  in   current array contents at this port's address
//   o_q      out  registered read data
//   o_valid  out  o_q updated this cycle
//
// Build option: TDP_RAM_OUT_REG_EN adds a second register stage (latency 2).
// ============================================================================
module tdp_ram_port_out
  import tdp_ram_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int RDW_MODE = RDW_WRITE_FIRST
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_access,
  input  logic              i_we,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [DATA_W-1:0] i_rdata,
  output logic [DATA_W-1:0] o_q,
  output logic              o_valid
);

  logic [DATA_W-1:0] r_q;
  logic              r_valid;
  logic [DATA_W-1:0] w_q_nxt;

  // Write-first forwards the incoming word; read-first (and plain reads)
  // return the array contents sampled before this edge's write lands.
  assign w_q_nxt = (i_we && (RDW_MODE == RDW_WRITE_FIRST)) ? i_wdata : i_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q     <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= i_access;
      if (i_access) begin
        r_q <= w_q_nxt;
      end
    end
  end

`ifdef TDP_RAM_OUT_REG_EN
  logic [DATA_W-1:0] r_q_d;
  logic              r_valid_d;

  // Data and valid travel together so the stream keeps its alignment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q_d     <= '0;
      r_valid_d <= 1'b0;
    end else begin
      r_q_d     <= r_q;
      r_valid_d <= r_valid;
    end
  end

  assign o_q     = r_q_d;
  assign o_valid = r_valid_d;
`else
  assign o_q     = r_q;
  assign o_valid = r_valid;
`endif

endmodule : tdp_ram_port_out
`default_nettype wire

// File: rtl/tdp_ram_param.sv
`default_nettype none
// ============================================================================
// Module      : tdp_ram_param
// Description : Parametrised true dual-port synchronous RAM with post-reset
//               clear sequencer, selectable read-during-write mode and
//               same-address write-collision arbitration (port A wins).
// Revision    : 1.0 - initial release
//
// Ports:
//   clk        in   single clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   init_busy  out  high while the clear sequence runs (ports ignored)
//   en_a/en_b  in   port access enable
//   we_a/we_b  in   port write enable (qualified by en)
//   addr_a/_b  in   port address, ADDR_W bits
//   data_a/_b  in   port write data, DATA_W bits
//   q_a/q_b    out  port read data
//   valid_a/_b out  q updated this cycle
//   collision  out  one-cycle pulse: both ports wrote one address last cycle
//
// Build option: TDP_RAM_OUT_REG_EN adds an output register stage on q/valid
//               and delays collision to match.
// ============================================================================
module tdp_ram_param
  import tdp_ram_pkg::*;
#(
  parameter int                DATA_W   = 8,
  parameter int                ADDR_W   = 6,
  parameter int                RDW_MODE = RDW_WRITE_FIRST,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              init_busy,
  input  logic              en_a,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] data_a,
  output logic [DATA_W-1:0] q_a,
  output logic              valid_a,
  input  logic              en_b,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] data_b,
  output logic [DATA_W-1:0] q_b,
  output logic              valid_b,
  output logic              collision
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];

  tdp_state_e        r_state;
  tdp_state_e        w_state_nxt;
  logic [ADDR_W:0]   r_clr_cnt;
  logic [ADDR_W:0]   w_clr_cnt_nxt;
  logic [ADDR_W:0]   w_clr_cnt_inc;

  logic              w_ready;
  logic              w_acc_a;
  logic              w_acc_b;
  logic              w_wr_a;
  logic              w_wr_b;
  logic              w_coll;
  logic [DATA_W-1:0] w_rd_a;
  logic [DATA_W-1:0] w_rd_b;
  logic              r_coll;

  // --------------------------------------------------------------------------
  // Clear sequencer
  // --------------------------------------------------------------------------
  // The counter carries one extra bit: the carry into bit ADDR_W marks the
  // last address without relying on the address field wrapping to zero.
  assign w_clr_cnt_inc = r_clr_cnt + (ADDR_W+1)'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_INIT;
      r_clr_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_cnt <= w_clr_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_clr_cnt_nxt = r_clr_cnt;
    case (r_state)
      ST_INIT: begin
        w_clr_cnt_nxt = w_clr_cnt_inc;
        if (w_clr_cnt_inc[ADDR_W]) begin
          w_state_nxt = ST_READY;
        end
      end
      ST_READY: begin
        w_state_nxt = ST_READY;
      end
      default: begin
        w_state_nxt = ST_INIT;
      end
    endcase
  end

  assign init_busy = (r_state == ST_INIT);
  assign w_ready   = (r_state == ST_READY);

  // --------------------------------------------------------------------------
  // Port qualification and collision arbitration
  // --------------------------------------------------------------------------
  assign w_acc_a = w_ready & en_a;
  assign w_acc_b = w_ready & en_b;
  assign w_wr_a  = w_acc_a & we_a;
  assign w_wr_b  = w_acc_b & we_b;
  assign w_coll  = w_wr_a & w_wr_b & (addr_a == addr_b);

  // Asynchronous array read: both ports see the contents before this edge's
  // writes, which gives old-data cross-port reads for free.
  assign w_rd_a = r_mem[addr_a];
  assign w_rd_b = r_mem[addr_b];

  // Array has no reset; the clear sequencer initialises it instead.
  always_ff @(posedge clk) begin
    if (r_state == ST_INIT) begin
      r_mem[r_clr_cnt[ADDR_W-1:0]] <= INIT_VAL;
    end else begin
      if (w_wr_a) begin
        r_mem[addr_a] <= data_a;
      end
      // Port B loses a same-address write race.
      if (w_wr_b && !w_coll) begin
        r_mem[addr_b] <= data_b;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_coll <= 1'b0;
    end else begin
      r_coll <= w_coll;
    end
  end

`ifdef TDP_RAM_OUT_REG_EN
  logic r_coll_d;

  // Keeps the flag aligned with the delayed valid strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_coll_d <= 1'b0;
    end else begin
      r_coll_d <= r_coll;
    end
  end

  assign collision = r_coll_d;
`else
  assign collision = r_coll;
`endif

  // --------------------------------------------------------------------------
  // Output registers
  // --------------------------------------------------------------------------
  tdp_ram_port_out #(
    .DATA_W   (DATA_W),
    .RDW_MODE (RDW_MODE)
  ) u_port_out_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_access (w_acc_a),
    .i_we     (we_a),
    .i_wdata  (data_a),
    .i_rdata  (w_rd_a),
    .o_q      (q_a),
    .o_valid  (valid_a)
  );

  tdp_ram_port_out #(
    .DATA_W   (DATA_W),
    .RDW_MODE (RDW_MODE)
  ) u_port_out_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_access (w_acc_b),
    .i_we     (we_b),
    .i_wdata  (data_b),
    .i_rdata  (w_rd_b),
    .o_q      (q_b),
    .o_valid  (valid_b)
  );

endmodule : tdp_ram_param
`default_nettype wire
